keccak_sched: RTL and testbench
===============================

// Module: keccak_sched
// PURPOSE
//  Round-robin scheduler that shares one keccak core among NREQ hash requesters.
//  Grants one requester at a time and issues start_calc with its mode.
//  Streams its 64-bit message words into the core, waits for out_ready, then drains the digest via gimme back to that requester.
//  Sits between the requester fabric and the single keccak instance.
// PARAMETERS
//  NREQ        4     number of requesters (2..8)
//  IDW         2     requester id width, $clog2(NREQ)
//  TIMEOUT     1024  ABSORB stall limit in cycles (used only with KECCAK_SCHED_TIMEOUT_EN)
// PORTS
//  clk            in   1        clock, rising edge
//  rst_n          in   1        synchronous reset, active-low
//  req            in   NREQ     per-requester hash request (level)
//  req_mode       in   2*NREQ   per-requester mode: 0=224, 1=256, 2=384, 3=512
//  req_data       in   64*NREQ  per-requester message word
//  req_valid      in   NREQ     message word valid
//  req_last       in   NREQ     marks last message word
//  req_ready      out  NREQ     word accepted (valid&ready = transfer)
//  core_start     out  1        to keccak start_calc
//  core_mode      out  2        to keccak mode
//  core_in        out  64       to keccak in
//  core_in_valid  out  1        to keccak in_valid
//  core_is_last   out  1        to keccak is_last
//  core_ack       in   1        keccak ack: word accepted this cycle
//  core_gimme     out  1        to keccak gimme: pop one digest word
//  core_out       in   64       keccak out
//  core_out_ready in   1        keccak digest available
//  core_out_empty in   1        keccak out_buf_empty
//  dig_data       out  64       digest word to owner
//  dig_valid      out  1        digest word valid
//  dig_ready      in   1        owner accepts digest word
//  dig_id         out  IDW      owner id of current transaction
//  dig_last       out  1        final digest word of transaction
//  busy           out  1        transaction in progress
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE, rr pointer=0, word counter=0, all outputs 0; aborts any transaction.
//  - FSM states:
//    IDLE:    if |req, grant the first set bit at or after rr pointer; latch id and mode; go START.
//    START:   core_start=1, core_mode=latched mode for exactly 1 cycle; go ABSORB.
//    ABSORB:  core_in=req_data[id], core_in_valid=req_valid[id], core_is_last=req_last[id], req_ready[id]=core_ack.
//             Other req_ready bits are 0. On a transfer with req_last, go WAIT.
//    WAIT:    on core_out_ready=1, go SQUEEZE.
//    SQUEEZE: dig_valid=!core_out_empty, dig_data=core_out, core_gimme=dig_valid&dig_ready.
//             Count pops. dig_last=1 on pop number DW(mode)-1. After that pop: rr pointer=id+1 (wraps), go IDLE.
//  - DW(mode) = digest words {4,4,6,8}; the 224-bit digest's upper 32 bits of word 3 are don't-care.
//  - Latency: grant to core_start = 1 cycle. IDLE is re-entered 1 cycle after the last pop, then the next grant follows.
//  - Once granted, the owner's req drop, mode change or other req edges are ignored until the transaction ends.
//  - Simultaneous requests are served strictly round-robin; a requester is never granted twice while another waits.
//  - Minimum message is 1 word (first word carries req_last).
//  - busy=1 in every state except IDLE. dig_id is held constant from grant until return to IDLE.
// CONFIGURATION
//  - KECCAK_SCHED_TIMEOUT_EN defined:
//    Adds outputs core_flush (1) and err_valid (1). A stall counter resets on each word transfer.
//    If the counter reaches TIMEOUT in ABSORB, then for 1 cycle core_flush=1 and err_valid=1 (dig_id = owner).
//    rr advances past the owner and the FSM goes to IDLE.
//  - Not defined: no ports added; ABSORB waits indefinitely.
// STRUCTURE
//  - Package keccak_sched_pkg: state enum, mode encodings, DW lookup function, MODE_W=2, WORD_W=64.
//  - Sub-module keccak_rr_arb: combinational round-robin picker (req, ptr -> one-hot grant + id).
//  - Top holds the FSM, counters and muxes.
// TESTING
//  1. Single requester 0, mode=1, 3 words (last on 3rd), core_ack always 1:
//     one core_start; 3 transfers with is_last on the 3rd; 4 digest pops; dig_last on the 4th.
//  2. req=4'b1111 held, mode=3, 1-word messages: grants in order 0,1,2,3,0; each gets 8 digest words; dig_id matches.
//  3. core_ack low for 5 cycles mid-message: req_ready[id]=0 during the stall; no word lost or duplicated.
//  4. dig_ready toggles 1,0,1,0: core_gimme only when dig_ready=1; exactly DW(mode) pops, mode=2 -> 6.
//  5. rst_n=0 during SQUEEZE: next cycle busy=0 and all outputs 0; a following request from requester 2 is granted first.
//  6. KECCAK_SCHED_TIMEOUT_EN, TIMEOUT=16, owner stops valid after word 1:
//     core_flush and err_valid pulse at stall cycle 16; the next requester is then granted.

Source files
------------

// File: rtl/keccak_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keccak_sched_pkg                                             |
// | Description : Shared types and helpers for the keccak request scheduler:   |
// |               FSM state encoding, digest mode encodings, word widths and   |
// |               the digest-length lookup.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package keccak_sched_pkg;

    localparam int MODE_W = 2;
    localparam int WORD_W = 64;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_ABSORB  = 3'd2,
        S_WAIT    = 3'd3,
        S_SQUEEZE = 3'd4
    } state_t;

    localparam logic [MODE_W-1:0] MODE_224 = 2'd0;
    localparam logic [MODE_W-1:0] MODE_256 = 2'd1;
    localparam logic [MODE_W-1:0] MODE_384 = 2'd2;
    localparam logic [MODE_W-1:0] MODE_512 = 2'd3;

    // Number of 64-bit words the core emits for a digest. The 224-bit digest
    // is rounded up to four words; the top half of its last word is junk.
    function automatic logic [3:0] dig_words(input logic [MODE_W-1:0] mode);
        case (mode)
            MODE_384: return 4'd6;
            MODE_512: return 4'd8;
            default:  return 4'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keccak_rr_arb                                                |
// | Description : Combinational round-robin picker. Grants the first set      |
// |               request bit found when scanning upward from ptr, wrapping.   |
// | Ports       : req   [NREQ] request vector                                 |
// |               ptr   [IDW]  highest-priority position (0..NREQ-1)           |
// |               grant [NREQ] one-hot grant, all zero when nothing requested  |
// |               id    [IDW]  index of the granted requester                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module keccak_rr_arb
    import keccak_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);

    int w_best;
    int w_dist;

    // Each requester's distance from ptr (mod NREQ) is its priority rank;
    // the requesting index with the smallest distance wins. Constant bit
    // indices keep this free of dynamic selects for non-power-of-two NREQ.
    always_comb begin
        w_best = NREQ;
        w_dist = 0;
        id     = '0;
        grant  = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_dist = j - int'(ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NREQ;
            end
            if (req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                id     = IDW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            grant[j] = (w_best < NREQ) && (id == IDW'(j));
        end
    end

endmodule
`default_nettype wire

// File: rtl/keccak_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keccak_sched                                                 |
// | Description : Round-robin scheduler sharing one keccak core among NREQ    |
// |               requesters. Grants one owner, pulses core_start with its     |
// |               mode, streams its message words into the core, waits for     |
// |               the digest, then pops it back to the owner word by word.     |
// | Ports       : clk, rst_n (synchronous, active-low)                         |
// |               req/req_mode/req_data/req_valid/req_last/req_ready : fabric  |
// |               core_* : keccak core side                                    |
// |               dig_data/dig_valid/dig_ready/dig_id/dig_last : digest return |
// |               busy : transaction in progress                               |
// | Options     : KECCAK_SCHED_TIMEOUT_EN adds core_flush/err_valid and aborts |
// |               an owner stalled in ABSORB for TIMEOUT cycles.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module keccak_sched
    import keccak_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [MODE_W*NREQ-1:0] req_mode,
    input  logic [WORD_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic                   core_start,
    output logic [MODE_W-1:0]      core_mode,
    output logic [WORD_W-1:0]      core_in,
    output logic                   core_in_valid,
    output logic                   core_is_last,
    input  logic                   core_ack,
    output logic                   core_gimme,
    input  logic [WORD_W-1:0]      core_out,
    input  logic                   core_out_ready,
    input  logic                   core_out_empty,
    output logic [WORD_W-1:0]      dig_data,
    output logic                   dig_valid,
    input  logic                   dig_ready,
    output logic [IDW-1:0]         dig_id,
    output logic                   dig_last,
`ifdef KECCAK_SCHED_TIMEOUT_EN
    output logic                   core_flush,
    output logic                   err_valid,
`endif
    output logic                   busy
);

    state_t              r_state;
    state_t              w_next_state;
    logic [IDW-1:0]      r_rr;
    logic [IDW-1:0]      r_id;
    logic [MODE_W-1:0]   r_mode;
    logic [2:0]          r_cnt;

    logic [NREQ-1:0]     w_grant;
    logic [IDW-1:0]      w_arb_id;
    logic [WORD_W-1:0]   w_data_arr [NREQ];
    logic [MODE_W-1:0]   w_mode_arr [NREQ];
    logic                w_xfer;
    logic                w_pop;
    logic                w_dw_last;
    logic                w_done;
    logic [IDW-1:0]      w_next_rr;

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_unpack
            assign w_data_arr[g] = req_data[WORD_W*g +: WORD_W];
            assign w_mode_arr[g] = req_mode[MODE_W*g +: MODE_W];
        end
    endgenerate

    keccak_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req),
        .ptr   (r_rr),
        .grant (w_grant),
        .id    (w_arb_id)
    );

    assign w_xfer    = (r_state == S_ABSORB) && req_valid[r_id] && core_ack;
    assign w_pop     = (r_state == S_SQUEEZE) && !core_out_empty && dig_ready;
    assign w_dw_last = ({1'b0, r_cnt} == (dig_words(r_mode) - 4'd1));
    assign w_done    = w_pop && w_dw_last;
    // Priority moves to the requester just after the owner that finished.
    assign w_next_rr = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);

    assign dig_id = r_id;
    assign busy   = (r_state != S_IDLE);

`ifdef KECCAK_SCHED_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] r_stall;
    logic               w_timeout;

    // r_stall counts consecutive ABSORB cycles without a word transfer;
    // the abort fires on the TIMEOUT-th such cycle.
    assign w_timeout = (r_state == S_ABSORB) && !w_xfer &&
                       (r_stall == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if ((r_state != S_ABSORB) || w_xfer) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end
`endif

    always_comb begin
        w_next_state  = r_state;
        req_ready     = '0;
        core_start    = 1'b0;
        core_mode     = '0;
        core_in       = '0;
        core_in_valid = 1'b0;
        core_is_last  = 1'b0;
        core_gimme    = 1'b0;
        dig_data      = '0;
        dig_valid     = 1'b0;
        dig_last      = 1'b0;
`ifdef KECCAK_SCHED_TIMEOUT_EN
        core_flush    = 1'b0;
        err_valid     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (|w_grant) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                core_start   = 1'b1;
                core_mode    = r_mode;
                w_next_state = S_ABSORB;
            end
            S_ABSORB: begin
                core_in         = w_data_arr[r_id];
                core_in_valid   = req_valid[r_id];
                core_is_last    = req_last[r_id];
                req_ready[r_id] = core_ack;
                if (w_xfer && req_last[r_id]) begin
                    w_next_state = S_WAIT;
                end
`ifdef KECCAK_SCHED_TIMEOUT_EN
                if (w_timeout) begin
                    core_flush   = 1'b1;
                    err_valid    = 1'b1;
                    w_next_state = S_IDLE;
                end
`endif
            end
            S_WAIT: begin
                if (core_out_ready) begin
                    w_next_state = S_SQUEEZE;
                end
            end
            S_SQUEEZE: begin
                dig_valid  = !core_out_empty;
                dig_data   = core_out;
                dig_last   = !core_out_empty && w_dw_last;
                core_gimme = w_pop;
                if (w_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_id    <= '0;
            r_mode  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            // Owner and mode are captured once; later req edges are ignored.
            if ((r_state == S_IDLE) && (|w_grant)) begin
                r_id   <= w_arb_id;
                r_mode <= w_mode_arr[w_arb_id];
            end
            if (w_pop) begin
                if (w_dw_last) begin
                    r_cnt <= '0;
                    r_rr  <= w_next_rr;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
`ifdef KECCAK_SCHED_TIMEOUT_EN
            if (w_timeout) begin
                r_rr <= w_next_rr;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_keccak_sched                                              |
// | Description : Self-checking bench for keccak_sched. Behavioural requesters |
// |               and a keccak core stub; expected digest words are queued     |
// |               when a request is set up and popped on each digest pop.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_keccak_sched;
    import keccak_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req, req_valid, req_last, req_ready;
    logic [2*NREQ-1:0]      req_mode;
    logic [64*NREQ-1:0]     req_data;
    logic                   core_start, core_in_valid, core_is_last, core_ack, core_gimme;
    logic [1:0]             core_mode;
    logic [63:0]            core_in, core_out, dig_data;
    logic                   core_out_ready, core_out_empty;
    logic                   dig_valid, dig_ready, dig_last, busy;
    logic [IDW-1:0]         dig_id;
`ifdef KECCAK_SCHED_TIMEOUT_EN
    logic                   core_flush, err_valid;
`endif

    always #5 clk = ~clk;

    keccak_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_mode(req_mode), .req_data(req_data),
        .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
        .core_start(core_start), .core_mode(core_mode), .core_in(core_in),
        .core_in_valid(core_in_valid), .core_is_last(core_is_last),
        .core_ack(core_ack), .core_gimme(core_gimme), .core_out(core_out),
        .core_out_ready(core_out_ready), .core_out_empty(core_out_empty),
        .dig_data(dig_data), .dig_valid(dig_valid), .dig_ready(dig_ready),
        .dig_id(dig_id), .dig_last(dig_last),
`ifdef KECCAK_SCHED_TIMEOUT_EN
        .core_flush(core_flush), .err_valid(err_valid),
`endif
        .busy(busy)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0]    data;
        logic           last;
    } dig_t;

    dig_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // requester model
    int         ntx [NREQ];
    int         len [NREQ];
    int         widx[NREQ];
    int         txn [NREQ];
    int         stall_after[NREQ];
    logic [1:0] mode_m[NREQ];

    // core stub and event counters
    logic [63:0] st_h;
    int          st_k, st_delay;
    logic        st_ready;
    int          ack_hold_at, ack_low;
    bit          dr_toggle;
    int          starts, xfers, pops, stalls, flushes, cyc, last_xfer_cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] msg_word(int id, int t, int w);
        return {8'(id), 8'(t), 16'(w), 32'(id * 32'h1357 + t * 32'h0BAD + w * 32'h00C0FFEE) ^ 32'h5A5A_A5A5};
    endfunction

    function automatic logic [63:0] dig_word(logic [63:0] h, int k);
        return h + 64'(k) * 64'h9E37_79B9_7F4A_7C15;
    endfunction

    function automatic int dwn(logic [1:0] m);
        case (m)
            2'd2:    return 6;
            2'd3:    return 8;
            default: return 4;
        endcase
    endfunction

    task automatic expect_txn(input int id, input int t);
        logic [63:0] h;
        int n;
        h = '0;
        for (int w = 0; w < len[id]; w++) h = h * 3 + msg_word(id, t, w);
        n = dwn(mode_m[id]);
        for (int k = 0; k < n; k++) exp_q.push_back('{id: IDW'(id), data: dig_word(h, k), last: (k == n - 1)});
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREQ; i++) begin
            ntx[i] = 0; len[i] = 1; widx[i] = 0; txn[i] = 0; stall_after[i] = -1; mode_m[i] = 2'd0;
        end
        exp_q.delete();
        st_h = '0; st_k = 0; st_delay = 0; st_ready = 1'b0;
        ack_hold_at = -1; ack_low = 0; dr_toggle = 1'b0;
    endtask

    task automatic zero_counts();
        starts = 0; xfers = 0; pops = 0; stalls = 0; flushes = 0;
    endtask

    // Sampled at negedge: everything seen here happens at the next posedge.
    task automatic observe();
        dig_t e;
        int   id;
        cyc++;
        id = int'(dig_id);
        if (st_delay > 0) begin
            st_delay--;
            if (st_delay == 0) st_ready = 1'b1;
        end
        if (core_start) begin
            starts++;
            chk("core_mode", 64'(core_mode), 64'(mode_m[id]));
            st_h = '0; st_k = 0; st_ready = 1'b0;
        end
        if (busy) chk("rdy_others", 64'(req_ready & ~(NREQ'(1) << dig_id)), 64'd0);
        if (core_in_valid) chk("rdy_own", 64'(req_ready[dig_id]), 64'(core_ack));
        if (core_in_valid && !core_ack) stalls++;
        if (core_in_valid && core_ack) begin
            xfers++;
            last_xfer_cyc = cyc;
            chk("core_in", core_in, msg_word(id, txn[id], widx[id]));
            chk("is_last", 64'(core_is_last), 64'(widx[id] == len[id] - 1));
            st_h = st_h * 3 + core_in;
            widx[id]++;
            if (core_is_last) st_delay = 3;
            if (xfers == ack_hold_at) ack_low = 5;
        end
        if (dig_valid) chk("gimme", 64'(core_gimme), 64'(dig_ready));
        if (dig_valid && dig_ready) begin
            pops++;
            st_k++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("dig_id", 64'(dig_id), 64'(e.id));
                chk("dig_data", dig_data, e.data);
                chk("dig_last", 64'(dig_last), 64'(e.last));
                if (e.last) begin
                    ntx[e.id]--; txn[e.id]++; widx[e.id] = 0; st_ready = 1'b0;
                end
            end
        end
`ifdef KECCAK_SCHED_TIMEOUT_EN
        chk("flush_err", 64'(core_flush), 64'(err_valid));
        if (core_flush) begin
            flushes++;
            chk("flush_id", 64'(dig_id), 64'd1);
            chk("flush_lat", 64'(cyc - last_xfer_cyc), 64'd16);
            ntx[id]--; txn[id]++; widx[id] = 0;
        end
`endif
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i]             = (ntx[i] > 0);
            req_mode[2*i +: 2] = mode_m[i];
            req_valid[i]       = (ntx[i] > 0) && (widx[i] < len[i]) &&
                                 ((stall_after[i] < 0) || (widx[i] < stall_after[i]));
            req_last[i]        = (widx[i] == len[i] - 1);
            req_data[64*i +: 64] = msg_word(i, txn[i], widx[i]);
        end
        core_ack = (ack_low == 0);
        if (ack_low > 0) ack_low--;
        core_out_ready = st_ready;
        core_out_empty = !st_ready;
        core_out       = dig_word(st_h, st_k);
        dig_ready      = dr_toggle ? !dig_ready : 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = !busy && (exp_q.size() == 0) && (ntx[0] + ntx[1] + ntx[2] + ntx[3] == 0);
        end
        chk({tag, "_timeout"}, 64'(done), 64'd1);
    endtask

    task automatic do_reset(input bit check);
        rst_n = 1'b0;
        clear_model();
        drive();
        @(posedge clk);
        #1;
        @(negedge clk);
        if (check) begin
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_dig_valid", 64'(dig_valid), 64'd0);
            chk("rst_gimme", 64'(core_gimme), 64'd0);
            chk("rst_start", 64'(core_start), 64'd0);
            chk("rst_in_valid", 64'(core_in_valid), 64'd0);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_dig_id", 64'(dig_id), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; dig_ready = 1'b1; cyc = 0; last_xfer_cyc = 0;
        clear_model();
        drive();
        do_reset(1'b1);

        // 1: single requester, mode 256, 3-word message
        zero_counts();
        mode_m[0] = 2'd1; len[0] = 3; ntx[0] = 1;
        expect_txn(0, 0);
        run_until_idle("t1", 200);
        chk("t1_starts", 64'(starts), 64'd1);
        chk("t1_xfers", 64'(xfers), 64'd3);
        chk("t1_pops", 64'(pops), 64'd4);

        // 2: all four requesting, mode 512, 1-word messages, strict rotation
        do_reset(1'b0);
        zero_counts();
        for (int i = 0; i < NREQ; i++) begin mode_m[i] = 2'd3; len[i] = 1; ntx[i] = 1; end
        ntx[0] = 2;
        expect_txn(0, 0); expect_txn(1, 0); expect_txn(2, 0); expect_txn(3, 0); expect_txn(0, 1);
        run_until_idle("t2", 600);
        chk("t2_starts", 64'(starts), 64'd5);
        chk("t2_pops", 64'(pops), 64'd40);

        // 3: core_ack stall of 5 cycles after the 2nd word
        do_reset(1'b0);
        zero_counts();
        mode_m[1] = 2'd0; len[1] = 5; ntx[1] = 1; ack_hold_at = 2;
        expect_txn(1, 0);
        run_until_idle("t3", 200);
        chk("t3_xfers", 64'(xfers), 64'd5);
        chk("t3_stalls", 64'(stalls), 64'd5);

        // 4: dig_ready toggling, mode 384 -> 6 pops; leaves rr pointer at 3
        do_reset(1'b0);
        zero_counts();
        mode_m[2] = 2'd2; len[2] = 2; ntx[2] = 1; dr_toggle = 1'b1;
        expect_txn(2, 0);
        run_until_idle("t4", 300);
        chk("t4_pops", 64'(pops), 64'd6);
        dr_toggle = 1'b0;

        // 5: reset in mid-SQUEEZE, then requesters 2 and 3 -> 2 first
        zero_counts();
        mode_m[3] = 2'd3; len[3] = 1; ntx[3] = 1;
        expect_txn(3, 0);
        for (int c = 0; c < 200 && pops < 3; c++) step();
        chk("t5_pre_pops", 64'(pops), 64'd3);
        do_reset(1'b1);
        zero_counts();
        mode_m[2] = 2'd0; len[2] = 2; ntx[2] = 1;
        mode_m[3] = 2'd0; len[3] = 2; ntx[3] = 1;
        expect_txn(2, 0); expect_txn(3, 0);
        run_until_idle("t5", 300);
        chk("t5_pops", 64'(pops), 64'd8);

`ifdef KECCAK_SCHED_TIMEOUT_EN
        // 6: owner 1 goes silent after one word; abort, then requester 2
        zero_counts();
        mode_m[1] = 2'd0; len[1] = 3; ntx[1] = 1; stall_after[1] = 1;
        mode_m[2] = 2'd1; len[2] = 1; ntx[2] = 1;
        expect_txn(2, 0);
        run_until_idle("t6", 300);
        chk("t6_flushes", 64'(flushes), 64'd1);
        chk("t6_starts", 64'(starts), 64'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
